// File: rtl/axi4_lite_multi_rif_adapter_if.sv
// AXI4-Lite bus bundle for the multi-port RIF adapter.
// slave = adapter side, master = interconnect/bench side.
interface axi4_lite_multi_rif_adapter_if #(
  parameter int ID_W   = 1,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awid, awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid,          output wready,
    output bid, bresp, bvalid,            input  bready,
    input  arid, araddr, arprot, arvalid, output arready,
    output rid, rdata, rresp, rvalid,     input  rready
  );

  modport master (
    output awid, awaddr, awprot, awvalid, input  awready,
    output wdata, wstrb, wvalid,          input  wready,
    input  bid, bresp, bvalid,            output bready,
    output arid, araddr, arprot, arvalid, input  arready,
    input  rid, rdata, rresp, rvalid,     output rready
  );
endinterface

// File: rtl/axi4_lite_multi_rif_adapter.sv
// AXI4-Lite slave fanning out to N_PORTS register-interface targets via buffered AW/W/AR/B/R FIFOs.
// Optional ack timeout: define AXI4_LITE_RIF_TIMEOUT_EN.
module axi4_lite_multi_rif_adapter_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PW-1:0]               wr_q, rd_q;
  logic [CW-1:0]               cnt_q;
  logic                        do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_q];

  // Storage is reset too so head-driven outputs read 0 out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
      end
      if (do_pop)
        rd_q <= (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

module axi4_lite_multi_rif_adapter #(
  parameter int AXI_ID_WIDTH   = 1,
  parameter int AXI_ADDR_WIDTH = 16,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int N_PORTS        = 4,
  parameter int PORT_SEL_WIDTH = (N_PORTS > 1) ? $clog2(N_PORTS) : 1,
  parameter int BUFFER_DEPTH   = 2,
  parameter int EN_SEC_MODE    = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  axi4_lite_multi_rif_adapter_if.slave      axi,
  output logic [AXI_ADDR_WIDTH-1:0]         rif_addr_w,
  output logic [AXI_DATA_WIDTH-1:0]         rif_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]       rif_wstrb,
  output logic [N_PORTS-1:0]                rif_wr_req,
  input  logic [N_PORTS-1:0]                rif_wr_ack,
  input  logic [N_PORTS-1:0]                rif_wr_err,
  output logic [AXI_ADDR_WIDTH-1:0]         rif_addr_r,
  output logic [N_PORTS-1:0]                rif_rd_req,
  input  logic [N_PORTS-1:0]                rif_rd_ack,
  input  logic [N_PORTS-1:0]                rif_rd_err,
  input  logic [N_PORTS*AXI_DATA_WIDTH-1:0] rif_rdata
);
  localparam int IW  = AXI_ID_WIDTH;
  localparam int AW  = AXI_ADDR_WIDTH;
  localparam int DW  = AXI_DATA_WIDTH;
  localparam int SW  = DW / 8;
  localparam int PSW = PORT_SEL_WIDTH;
  localparam logic [PSW:0] NP = (PSW + 1)'(N_PORTS);
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

  generate
    if (BUFFER_DEPTH < 1) begin : g_bad_depth
      $fatal(1, "BUFFER_DEPTH must be >= 1");
    end
    if (DW != 32 && DW != 64) begin : g_bad_width
      $fatal(1, "AXI_DATA_WIDTH must be 32 or 64");
    end
    if (N_PORTS < 1 || N_PORTS > 16) begin : g_bad_ports
      $fatal(1, "N_PORTS must be in 1..16");
    end
  endgenerate

  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_RESP} rstate_e;

  // ---------------- FIFOs ----------------
  logic [IW-1:0] aw_id, ar_id;
  logic [AW-1:0] aw_addr, ar_addr;
  logic          aw_ns, ar_ns;
  logic [DW-1:0] w_data;
  logic [SW-1:0] w_strb;
  logic awf_full, awf_empty, awf_pop;
  logic wf_full, wf_empty, wf_pop;
  logic arf_full, arf_empty, arf_pop;
  logic bf_full, bf_empty, bf_push;
  logic rf_full, rf_empty, rf_push;
  logic unused_prot;

  assign axi.awready = !awf_full;
  assign axi.wready  = !wf_full;
  assign axi.arready = !arf_full;
  // Only the non-secure bit of prot matters to this block.
  assign unused_prot = ^{axi.awprot[2], axi.awprot[0], axi.arprot[2], axi.arprot[0], rf_full};

  axi4_lite_multi_rif_adapter_fifo #(.WIDTH(IW + AW + 1), .DEPTH(BUFFER_DEPTH)) u_awf (
    .clk_i(aclk), .rst_ni(aresetn),
    .push_i(axi.awvalid), .din_i({axi.awid, axi.awaddr, axi.awprot[1]}),
    .pop_i(awf_pop), .dout_o({aw_id, aw_addr, aw_ns}),
    .full_o(awf_full), .empty_o(awf_empty)
  );

  axi4_lite_multi_rif_adapter_fifo #(.WIDTH(DW + SW), .DEPTH(BUFFER_DEPTH)) u_wf (
    .clk_i(aclk), .rst_ni(aresetn),
    .push_i(axi.wvalid), .din_i({axi.wdata, axi.wstrb}),
    .pop_i(wf_pop), .dout_o({w_data, w_strb}),
    .full_o(wf_full), .empty_o(wf_empty)
  );

  axi4_lite_multi_rif_adapter_fifo #(.WIDTH(IW + AW + 1), .DEPTH(BUFFER_DEPTH)) u_arf (
    .clk_i(aclk), .rst_ni(aresetn),
    .push_i(axi.arvalid), .din_i({axi.arid, axi.araddr, axi.arprot[1]}),
    .pop_i(arf_pop), .dout_o({ar_id, ar_addr, ar_ns}),
    .full_o(arf_full), .empty_o(arf_empty)
  );

  logic [1:0]    wresp_q, wresp_d;
  logic [1:0]    rresp_q, rresp_d;
  logic [DW-1:0] rdata_q, rdata_d;

  axi4_lite_multi_rif_adapter_fifo #(.WIDTH(IW + 2), .DEPTH(BUFFER_DEPTH)) u_bf (
    .clk_i(aclk), .rst_ni(aresetn),
    .push_i(bf_push), .din_i({aw_id, wresp_q}),
    .pop_i(axi.bvalid && axi.bready), .dout_o({axi.bid, axi.bresp}),
    .full_o(bf_full), .empty_o(bf_empty)
  );

  axi4_lite_multi_rif_adapter_fifo #(.WIDTH(IW + 2 + DW), .DEPTH(BUFFER_DEPTH)) u_rf (
    .clk_i(aclk), .rst_ni(aresetn),
    .push_i(rf_push), .din_i({ar_id, rresp_q, rdata_q}),
    .pop_i(axi.rvalid && axi.rready), .dout_o({axi.rid, axi.rresp, axi.rdata}),
    .full_o(rf_full), .empty_o(rf_empty)
  );

  assign axi.bvalid = !bf_empty;
  assign axi.rvalid = !rf_empty;

  // ---------------- RIF request / ack steering ----------------
  wstate_e        wstate_q, wstate_d;
  rstate_e        rstate_q, rstate_d;
  logic [PSW-1:0] aw_port, ar_port;
  logic           wr_ack, wr_err, rd_ack, rd_err;
  logic [DW-1:0]  rsel_data;

  assign aw_port = aw_addr[AW-1 -: PSW];
  assign ar_port = ar_addr[AW-1 -: PSW];

  // The port comes straight from the FIFO head, which cannot pop until RESP,
  // so the one-hot request and shared buses hold stable through REQ.
  always_comb begin
    rif_wr_req = '0;
    rif_rd_req = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      rif_wr_req[p] = (wstate_q == W_REQ) && ({1'b0, aw_port} == (PSW + 1)'(p));
      rif_rd_req[p] = (rstate_q == R_REQ) && ({1'b0, ar_port} == (PSW + 1)'(p));
    end
  end

  assign wr_ack = |(rif_wr_ack & rif_wr_req);
  assign wr_err = |(rif_wr_err & rif_wr_req);
  assign rd_ack = |(rif_rd_ack & rif_rd_req);
  assign rd_err = |(rif_rd_err & rif_rd_req);

  always_comb begin
    rsel_data = '0;
    for (int p = 0; p < N_PORTS; p++)
      if (rif_rd_req[p]) rsel_data = rif_rdata[p*DW +: DW];
  end

  assign rif_addr_w = (wstate_q == W_REQ) ? aw_addr : '0;
  assign rif_wdata  = (wstate_q == W_REQ) ? w_data  : '0;
  assign rif_wstrb  = (wstate_q == W_REQ) ? w_strb  : '0;
  assign rif_addr_r = (rstate_q == R_REQ) ? ar_addr : '0;

`ifdef AXI4_LITE_RIF_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  // Compared against TIMEOUT_CYCLES-1: the current ack-less cycle is the one that reaches the limit.
  localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT_CYCLES - 1);
  logic [TCW-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
`endif

  // ---------------- write FSM ----------------
  always_comb begin
    wstate_d = wstate_q;
    wresp_d  = wresp_q;
    bf_push  = 1'b0;
    awf_pop  = 1'b0;
    wf_pop   = 1'b0;
`ifdef AXI4_LITE_RIF_TIMEOUT_EN
    wcnt_d   = wcnt_q;
`endif
    case (wstate_q)
      W_IDLE: if (!awf_empty && !wf_empty && !bf_full) begin
        if ({1'b0, aw_port} >= NP) begin
          wresp_d  = DECERR;
          wstate_d = W_RESP;
        end else if (EN_SEC_MODE != 0 && aw_ns) begin
          wresp_d  = SLVERR;
          wstate_d = W_RESP;
        end else begin
          wstate_d = W_REQ;
`ifdef AXI4_LITE_RIF_TIMEOUT_EN
          wcnt_d   = '0;
`endif
        end
      end
      W_REQ: begin
        if (wr_ack) begin
          wresp_d  = wr_err ? SLVERR : OKAY;
          wstate_d = W_RESP;
        end
`ifdef AXI4_LITE_RIF_TIMEOUT_EN
        else if (wcnt_q == TO_LAST) begin
          wresp_d  = SLVERR;
          wstate_d = W_RESP;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
`endif
      end
      W_RESP: begin
        bf_push  = 1'b1;
        awf_pop  = 1'b1;
        wf_pop   = 1'b1;
        wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // ---------------- read FSM ----------------
  always_comb begin
    rstate_d = rstate_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    rf_push  = 1'b0;
    arf_pop  = 1'b0;
`ifdef AXI4_LITE_RIF_TIMEOUT_EN
    rcnt_d   = rcnt_q;
`endif
    case (rstate_q)
      R_IDLE: if (!arf_empty && !rf_full) begin
        rdata_d = '0;
        if ({1'b0, ar_port} >= NP) begin
          rresp_d  = DECERR;
          rstate_d = R_RESP;
        end else if (EN_SEC_MODE != 0 && ar_ns) begin
          rresp_d  = SLVERR;
          rstate_d = R_RESP;
        end else begin
          rstate_d = R_REQ;
`ifdef AXI4_LITE_RIF_TIMEOUT_EN
          rcnt_d   = '0;
`endif
        end
      end
      R_REQ: begin
        if (rd_ack) begin
          rresp_d  = rd_err ? SLVERR : OKAY;
          rdata_d  = rd_err ? '0 : rsel_data;
          rstate_d = R_RESP;
        end
`ifdef AXI4_LITE_RIF_TIMEOUT_EN
        else if (rcnt_q == TO_LAST) begin
          rresp_d  = SLVERR;
          rdata_d  = '0;
          rstate_d = R_RESP;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
`endif
      end
      R_RESP: begin
        rf_push  = 1'b1;
        arf_pop  = 1'b1;
        rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wstate_q <= W_IDLE;
      rstate_q <= R_IDLE;
      wresp_q  <= OKAY;
      rresp_q  <= OKAY;
      rdata_q  <= '0;
`ifdef AXI4_LITE_RIF_TIMEOUT_EN
      wcnt_q   <= '0;
      rcnt_q   <= '0;
`endif
    end else begin
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
      wresp_q  <= wresp_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
`ifdef AXI4_LITE_RIF_TIMEOUT_EN
      wcnt_q   <= wcnt_d;
      rcnt_q   <= rcnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_axi4_lite_multi_rif_adapter.sv
// Scoreboard bench for axi4_lite_multi_rif_adapter: N_PORTS=3, BUFFER_DEPTH=2, secure mode on.
module tb_axi4_lite_multi_rif_adapter;
  localparam int IW = 4, AW = 16, DW = 32, NP = 3, DEPTH = 2, TO = 8;

  logic aclk, aresetn;
  logic [AW-1:0]    rif_addr_w, rif_addr_r;
  logic [DW-1:0]    rif_wdata;
  logic [DW/8-1:0]  rif_wstrb;
  logic [NP-1:0]    rif_wr_req, rif_wr_ack, rif_wr_err;
  logic [NP-1:0]    rif_rd_req, rif_rd_ack, rif_rd_err;
  logic [NP*DW-1:0] rif_rdata;

  axi4_lite_multi_rif_adapter_if #(.ID_W(IW), .ADDR_W(AW), .DATA_W(DW)) bus ();

  axi4_lite_multi_rif_adapter #(
    .AXI_ID_WIDTH(IW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .N_PORTS(NP),
    .BUFFER_DEPTH(DEPTH), .EN_SEC_MODE(1), .TIMEOUT_CYCLES(TO)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .axi(bus),
    .rif_addr_w(rif_addr_w), .rif_wdata(rif_wdata), .rif_wstrb(rif_wstrb),
    .rif_wr_req(rif_wr_req), .rif_wr_ack(rif_wr_ack), .rif_wr_err(rif_wr_err),
    .rif_addr_r(rif_addr_r), .rif_rd_req(rif_rd_req), .rif_rd_ack(rif_rd_ack),
    .rif_rd_err(rif_rd_err), .rif_rdata(rif_rdata)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_tests = 0, n_fail = 0;
  logic [IW+1:0]    exp_b[$];
  logic [IW+1+DW:0] exp_r[$];

  // RIF target model: ack after a programmable number of req cycles
  bit wr_ack_en = 1, rd_ack_en = 1, wr_err_cfg = 0, rd_err_cfg = 0;
  int wr_delay = 0, rd_delay = 0, wcnt = 0, rcnt = 0, wr_acks = 0;
  bit wr_seen = 0, rd_seen = 0;
  logic [NP-1:0] rd_force = '0;

  initial begin
    rif_wr_ack = '0; rif_wr_err = '0; rif_rd_ack = '0; rif_rd_err = '0;
    forever begin
      @(negedge aclk);
      if (rif_wr_req != '0) wr_seen = 1;
      if (rif_rd_req != '0) rd_seen = 1;
      if (wr_ack_en && rif_wr_req != '0 && wcnt == wr_delay) begin
        rif_wr_ack = rif_wr_req;
        rif_wr_err = wr_err_cfg ? rif_wr_req : '0;
        wr_acks++;
      end else begin
        rif_wr_ack = '0;
        rif_wr_err = '0;
      end
      if (rd_ack_en && rif_rd_req != '0 && rcnt == rd_delay) begin
        rif_rd_ack = rif_rd_req;
        rif_rd_err = rd_err_cfg ? rif_rd_req : '0;
      end else begin
        rif_rd_ack = rd_ack_en ? '0 : rd_force;
        rif_rd_err = '0;
      end
      wcnt = (rif_wr_req != '0) ? wcnt + 1 : 0;
      rcnt = (rif_rd_req != '0) ? rcnt + 1 : 0;
    end
  end

  // Response monitor: pops the scoreboard on every accepted B/R beat
  initial begin
    logic [IW+1:0]    eb;
    logic [IW+1+DW:0] er;
    forever begin
      @(negedge aclk);
      if (aresetn && bus.bvalid && bus.bready) begin
        n_tests++;
        if (exp_b.size() == 0) begin
          n_fail++;
          $display("FAIL b_unexpected: got id=%0h resp=%0h, required no response", bus.bid, bus.bresp);
        end else begin
          eb = exp_b.pop_front();
          if ({bus.bid, bus.bresp} !== eb) begin
            n_fail++;
            $display("FAIL b_beat: got id=%0h resp=%0h, required id=%0h resp=%0h",
                     bus.bid, bus.bresp, eb[IW+1:2], eb[1:0]);
          end
        end
      end
      if (aresetn && bus.rvalid && bus.rready) begin
        n_tests++;
        if (exp_r.size() == 0) begin
          n_fail++;
          $display("FAIL r_unexpected: got id=%0h resp=%0h data=%h, required no response",
                   bus.rid, bus.rresp, bus.rdata);
        end else begin
          er = exp_r.pop_front();
          if ({bus.rid, bus.rresp, bus.rdata} !== er) begin
            n_fail++;
            $display("FAIL r_beat: got id=%0h resp=%0h data=%h, required id=%0h resp=%0h data=%h",
                     bus.rid, bus.rresp, bus.rdata, er[IW+1+DW:DW+2], er[DW+1:DW], er[DW-1:0]);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic send_aw(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [2:0] prot);
    bit rdy = 0;
    int n = 0;
    @(posedge aclk); #1;
    bus.awid = id; bus.awaddr = addr; bus.awprot = prot; bus.awvalid = 1'b1;
    while (!rdy && n < 200) begin
      rdy = bus.awready;
      @(posedge aclk); #1;
      n++;
    end
    bus.awvalid = 1'b0;
    if (!rdy) begin
      n_tests++; n_fail++;
      $display("FAIL aw_handshake: awready stayed 0 for %0d cycles, required acceptance", n);
    end
  endtask

  task automatic send_w(input logic [DW-1:0] data, input logic [DW/8-1:0] strb);
    bit rdy = 0;
    int n = 0;
    @(posedge aclk); #1;
    bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
    while (!rdy && n < 200) begin
      rdy = bus.wready;
      @(posedge aclk); #1;
      n++;
    end
    bus.wvalid = 1'b0;
    if (!rdy) begin
      n_tests++; n_fail++;
      $display("FAIL w_handshake: wready stayed 0 for %0d cycles, required acceptance", n);
    end
  endtask

  task automatic send_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [2:0] prot);
    bit rdy = 0;
    int n = 0;
    @(posedge aclk); #1;
    bus.arid = id; bus.araddr = addr; bus.arprot = prot; bus.arvalid = 1'b1;
    while (!rdy && n < 200) begin
      rdy = bus.arready;
      @(posedge aclk); #1;
      n++;
    end
    bus.arvalid = 1'b0;
    if (!rdy) begin
      n_tests++; n_fail++;
      $display("FAIL ar_handshake: arready stayed 0 for %0d cycles, required acceptance", n);
    end
  endtask

  task automatic drain(output bit ok);
    int n = 0;
    while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 300) begin
      @(negedge aclk);
      n++;
    end
    ok = (exp_b.size() == 0 && exp_r.size() == 0);
    repeat (4) @(negedge aclk);
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0; bus.bready = 1; bus.rready = 1;
    bus.awid = '0; bus.awaddr = '0; bus.awprot = '0; bus.wdata = '0; bus.wstrb = '0;
    bus.arid = '0; bus.araddr = '0; bus.arprot = '0;
    rif_rdata = '0;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(negedge aclk);
    n_tests++;
    if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
      n_fail++; $display("FAIL reset_ready: got %b, required 111", {bus.awready, bus.wready, bus.arready});
    end
    n_tests++;
    if ({bus.bvalid, bus.rvalid} !== 2'b00) begin
      n_fail++; $display("FAIL reset_valid: got %b, required 00", {bus.bvalid, bus.rvalid});
    end
    n_tests++;
    if ({bus.bresp, bus.rresp, bus.bid, bus.rid} !== '0) begin
      n_fail++; $display("FAIL reset_resp_id: got bresp=%0h rresp=%0h bid=%0h rid=%0h, required 0",
                         bus.bresp, bus.rresp, bus.bid, bus.rid);
    end
    n_tests++;
    if (bus.rdata !== '0) begin
      n_fail++; $display("FAIL reset_rdata: got %h, required 0", bus.rdata);
    end
    n_tests++;
    if ({rif_wr_req, rif_rd_req} !== '0) begin
      n_fail++; $display("FAIL reset_req: got wr=%b rd=%b, required 0", rif_wr_req, rif_rd_req);
    end
    n_tests++;
    if ({rif_addr_w, rif_wdata, rif_wstrb, rif_addr_r} !== '0) begin
      n_fail++; $display("FAIL reset_rif_bus: got aw=%h wd=%h ws=%h ar=%h, required 0",
                         rif_addr_w, rif_wdata, rif_wstrb, rif_addr_r);
    end
  endtask

  task automatic test_write_wait();
    int n = 0, cyc = 0;
    bit stable = 1, ok;
    wr_delay = 2;
    exp_b.push_back({4'h5, 2'b00});
    send_aw(4'h5, 16'h4010, 3'b000);
    repeat (2) @(posedge aclk);
    send_w(32'hCAFE_0001, 4'b1011);
    while (rif_wr_req == '0 && n < 50) begin
      @(negedge aclk);
      n++;
    end
    n_tests++;
    if (rif_wr_req !== 3'b010) begin
      n_fail++; $display("FAIL write_req_onehot: got %b, required 010", rif_wr_req);
    end
    while (rif_wr_req != '0 && cyc < 50) begin
      if (rif_addr_w !== 16'h4010 || rif_wdata !== 32'hCAFE_0001 || rif_wstrb !== 4'b1011) stable = 0;
      cyc++;
      @(negedge aclk);
    end
    n_tests++;
    if (stable !== 1'b1) begin
      n_fail++; $display("FAIL write_req_stable: addr/data/strb changed during req, required stable 4010/cafe0001/1011");
    end
    n_tests++;
    if (cyc !== 3) begin
      n_fail++; $display("FAIL write_req_len: got %0d req cycles, required 3", cyc);
    end
    drain(ok);
    n_tests++;
    if (ok !== 1'b1) begin
      n_fail++; $display("FAIL write_wait_drain: pending b=%0d, required 0", exp_b.size());
    end
    wr_delay = 0;
  endtask

  task automatic test_decerr();
    bit ok;
    wr_seen = 0; rd_seen = 0;
    rif_rdata = {3{32'hDEAD_BEEF}};
    exp_b.push_back({4'h1, 2'b11});
    exp_r.push_back({4'h2, 2'b11, 32'h0});
    send_aw(4'h1, 16'hC000, 3'b000);
    send_w(32'h1111_2222, 4'hF);
    send_ar(4'h2, 16'hC004, 3'b000);
    drain(ok);
    n_tests++;
    if (ok !== 1'b1) begin
      n_fail++; $display("FAIL decerr_drain: pending b=%0d r=%0d, required 0", exp_b.size(), exp_r.size());
    end
    n_tests++;
    if ({wr_seen, rd_seen} !== 2'b00) begin
      n_fail++; $display("FAIL decerr_no_req: got wr_seen=%0d rd_seen=%0d, required 0 0", wr_seen, rd_seen);
    end
  endtask

  task automatic test_secure();
    bit ok;
    rif_rdata = '0;
    rif_rdata[0 +: DW] = 32'hA5A5_0001;
    rd_seen = 0; wr_seen = 0;
    exp_r.push_back({4'h3, 2'b10, 32'h0});
    send_ar(4'h3, 16'h0004, 3'b010);
    exp_b.push_back({4'h6, 2'b10});
    send_aw(4'h6, 16'h8000, 3'b010);
    send_w(32'h5555_AAAA, 4'hF);
    drain(ok);
    n_tests++;
    if (ok !== 1'b1) begin
      n_fail++; $display("FAIL secure_reject_drain: pending b=%0d r=%0d, required 0", exp_b.size(), exp_r.size());
    end
    n_tests++;
    if ({wr_seen, rd_seen} !== 2'b00) begin
      n_fail++; $display("FAIL secure_no_req: got wr_seen=%0d rd_seen=%0d, required 0 0", wr_seen, rd_seen);
    end
    exp_r.push_back({4'h4, 2'b00, 32'hA5A5_0001});
    send_ar(4'h4, 16'h0008, 3'b000);
    drain(ok);
    n_tests++;
    if (ok !== 1'b1 || rd_seen !== 1'b1) begin
      n_fail++; $display("FAIL secure_ok_read: drained=%0d rd_seen=%0d, required 1 1", ok, rd_seen);
    end
  endtask

  task automatic test_rif_err();
    bit ok;
    rif_rdata[DW +: DW]   = 32'h1234_5678;
    rif_rdata[2*DW +: DW] = 32'h0BAD_F00D;
    rd_err_cfg = 1;
    exp_r.push_back({4'h7, 2'b10, 32'h0});
    send_ar(4'h7, 16'h4000, 3'b000);
    drain(ok);
    rd_err_cfg = 0;
    wr_err_cfg = 1;
    exp_b.push_back({4'h8, 2'b10});
    send_aw(4'h8, 16'h8020, 3'b000);
    send_w(32'h0, 4'h1);
    drain(ok);
    wr_err_cfg = 0;
    rd_delay = 1;
    exp_r.push_back({4'h9, 2'b00, 32'h0BAD_F00D});
    send_ar(4'h9, 16'h8010, 3'b000);
    drain(ok);
    rd_delay = 0;
    n_tests++;
    if (ok !== 1'b1) begin
      n_fail++; $display("FAIL rif_err_drain: pending b=%0d r=%0d, required 0", exp_b.size(), exp_r.size());
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bus.bready = 1'b0;
    wr_acks = 0;
    for (int i = 0; i < 4; i++) begin
      exp_b.push_back({4'(i + 10), 2'b00});
      send_aw(4'(i + 10), 16'(16'h4000 + i * 4), 3'b000);
      send_w(32'(i), 4'hF);
    end
    repeat (8) @(negedge aclk);
    n_tests++;
    if ({bus.awready, bus.wready} !== 2'b00) begin
      n_fail++; $display("FAIL bp_ready: got awready=%b wready=%b, required 0 0", bus.awready, bus.wready);
    end
    n_tests++;
    if (bus.bvalid !== 1'b1) begin
      n_fail++; $display("FAIL bp_bvalid: got %b, required 1", bus.bvalid);
    end
    n_tests++;
    if (wr_acks !== 2) begin
      n_fail++; $display("FAIL bp_stall: got %0d rif writes, required 2", wr_acks);
    end
    @(posedge aclk); #1 bus.bready = 1'b1;
    drain(ok);
    n_tests++;
    if (ok !== 1'b1 || wr_acks !== 4) begin
      n_fail++; $display("FAIL bp_release: drained=%0d rif writes=%0d, required 1 4", ok, wr_acks);
    end
  endtask

`ifdef AXI4_LITE_RIF_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int n = 0, cyc = 0;
    rd_ack_en = 0; rd_force = '0;
    exp_r.push_back({4'h5, 2'b10, 32'h0});
    send_ar(4'h5, 16'h4000, 3'b000);
    while (rif_rd_req == '0 && n < 50) begin
      @(negedge aclk);
      n++;
    end
    while (rif_rd_req != '0 && cyc < 50) begin
      cyc++;
      @(negedge aclk);
    end
    rd_force = 3'b010;
    @(negedge aclk);
    rd_force = '0;
    n_tests++;
    if (cyc !== TO) begin
      n_fail++; $display("FAIL timeout_len: got %0d req cycles, required %0d", cyc, TO);
    end
    drain(ok);
    n_tests++;
    if (ok !== 1'b1 || bus.rvalid !== 1'b0) begin
      n_fail++; $display("FAIL timeout_resp: drained=%0d rvalid=%b, required 1 0", ok, bus.rvalid);
    end
    rd_ack_en = 1;
  endtask
`endif

  task automatic test_reset_mid();
    bit ok;
    int n = 0;
    wr_ack_en = 0;
    send_aw(4'h2, 16'h8000, 3'b000);
    send_w(32'hFEED_0000, 4'hF);
    while (rif_wr_req == '0 && n < 50) begin
      @(negedge aclk);
      n++;
    end
    n_tests++;
    if (rif_wr_req !== 3'b100) begin
      n_fail++; $display("FAIL rst_mid_req_before: got %b, required 100", rif_wr_req);
    end
    aresetn = 1'b0;
    #1;
    n_tests++;
    if (rif_wr_req !== 3'b000 || bus.bvalid !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_async: got req=%b bvalid=%b, required 000 0", rif_wr_req, bus.bvalid);
    end
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    wr_ack_en = 1;
    @(negedge aclk);
    n_tests++;
    if ({bus.awready, bus.wready, bus.arready, bus.bvalid} !== 4'b1110) begin
      n_fail++; $display("FAIL rst_mid_empty: got aw/w/ar ready, bvalid=%b, required 1110",
                         {bus.awready, bus.wready, bus.arready, bus.bvalid});
    end
    exp_b.push_back({4'h3, 2'b00});
    send_aw(4'h3, 16'h0000, 3'b000);
    send_w(32'h0000_0001, 4'hF);
    drain(ok);
    n_tests++;
    if (ok !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_after: pending b=%0d, required 0", exp_b.size());
    end
  endtask

  initial begin
    test_reset();
    test_write_wait();
    test_decerr();
    test_secure();
    test_rif_err();
    test_back_to_back();
`ifdef AXI4_LITE_RIF_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
